// File: rtl/data_mem_unit.sv
// Multi-cycle RV32 data memory with configurable depth/latency, valid/ready
// handshakes on request and response, byte/half/word sizing and fault reporting.
module data_mem_unit #(
  parameter int DEPTH  = 1024,
  parameter int LAT    = 2,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic [31:0]   mem [DEPTH];

  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic          illegal, misaligned, out_of_range, err;
  logic [31:0]   cur_word, ld_shift, ld_data, wshift;
  logic [3:0]    be;
  logic          accept, do_write;

  assign word_idx  = req_addr[AW+1:2];
  assign lane      = req_addr[1:0];
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = (state == IDLE) && req_valid;
  assign do_write  = accept && !rst && req_we && !err;

  // Request decode: fault detection, load extraction and store lane enables
  always_comb begin
    illegal      = 1'b0;
    misaligned   = 1'b0;
    out_of_range = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = req_we;
      default:                illegal = 1'b1;
    endcase
    if (req_funct3[1:0] == 2'b01 && lane[0])
      misaligned = 1'b1;
    if (req_funct3[1:0] == 2'b10 && lane != 2'b00)
      misaligned = 1'b1;
    for (int i = AW + 2; i < ADDR_W; i++)
      out_of_range = out_of_range | req_addr[i];
    err = illegal | misaligned | out_of_range;

    cur_word = mem[word_idx];
    ld_shift = cur_word >> {lane, 3'b000};
    case (req_funct3[1:0])
      2'b00:   ld_data = req_funct3[2] ? {24'b0, ld_shift[7:0]}
                                       : {{24{ld_shift[7]}}, ld_shift[7:0]};
      2'b01:   ld_data = req_funct3[2] ? {16'b0, ld_shift[15:0]}
                                       : {{16{ld_shift[15]}}, ld_shift[15:0]};
      default: ld_data = cur_word;
    endcase

    wshift = req_wdata << {lane, 3'b000};
    case (req_funct3[1:0])
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = 4'b0011 << lane;
      default: be = 4'b1111;
    endcase
  end

  // Storage is deliberately left out of reset; stores commit at acceptance
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int k = 0; k < 4; k++)
        if (be[k])
          mem[word_idx][8*k +: 8] <= wshift[8*k +: 8];
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (LAT == 1) begin
            state_nxt = RESP;
          end else begin
            cnt_nxt   = CW'(LAT - 1);
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1))
          state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Response fields are captured once at acceptance and held through RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        rsp_err   <= err;
        rsp_rdata <= (err || req_we) ? 32'h0 : ld_data;
      end
    end
  end

endmodule
